card_deck_gen: RTL and testbench
================================

# card_deck_gen

Pseudo-random deck source that feeds the blackjack game controller. On `start` it seeds a 16-bit LFSR and fills a DECK_SIZE-entry card buffer. Each card is a blackjack value with an ace flag, produced by rejection sampling. It then serves cards one per `draw_req` with a registered valid pulse, so the game FSM no longer builds its own deck.

## Interface
- `DECK_SIZE`, 12: number of cards generated per fill (2..15).
- `CNT_W`, 4: width of `cards_left`; must satisfy 2^CNT_W > DECK_SIZE.
- `clk`  in  1: system clock (CLOCK_50).
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request to (re)build the deck.
- `seed`  in  16: LFSR seed, sampled on accepted `start`.
- `draw_req`  in  1: request the next card.
- `busy`  out  1: deck fill in progress.
- `deck_ready`  out  1: deck filled and at least one card remaining.
- `deck_empty`  out  1: all DECK_SIZE cards drawn.
- `card_valid`  out  1: one-cycle pulse; `card_val`/`card_ace` valid.
- `card_val`  out  4: card points, 1..10 (ace = 1).
- `card_ace`  out  1: card is an ace.
- `cards_left`  out  CNT_W: undrawn cards in the buffer.

## Operation
- States: IDLE, FILL, READY, EMPTY. After reset the block is in IDLE.
- Accepting `start`: accepted in IDLE, READY and EMPTY.
  - On acceptance: LFSR <= (seed == 0) ? 16'hACE1 : seed; write pointer, read pointer and `cards_left` cleared; next state is FILL.
- `start` during FILL is ignored.
- LFSR update: Galois, right-shift. Next = (s >> 1) ^ (s[0] ? 16'hB400 : 0). It steps exactly once per FILL cycle and holds in all other states.
- Each FILL cycle samples r = s[3:0] (current state, before the step).
  - If r <= 12: rank = r + 1; card_val = min(rank, 10); card_ace = (rank == 1). The card is written at the write pointer, the write pointer increments, and `cards_left` increments.
  - If r >= 13: the sample is rejected; no write occurs, but the LFSR still steps.
- FILL -> READY in the cycle after the write that makes the count reach DECK_SIZE.
- Draw in READY: `draw_req` high causes the card at the read pointer to appear registered next cycle with `card_valid` = 1. The read pointer then increments and `cards_left` decrements.
- READY -> EMPTY when a draw brings `cards_left` to 0.
- `draw_req` in IDLE, FILL or EMPTY is ignored: no pulse, no pointer change.
- `start` and `draw_req` high together in READY: `start` wins and no card is delivered.
- Output decodes: `busy` = (state == FILL); `deck_ready` = (state == READY); `deck_empty` = (state == EMPTY).
- `card_val`/`card_ace` hold their last delivered value while `card_valid` = 0.

## Timing
- Reset values: all outputs are 0, including `cards_left` = 0, `card_val` = 0 and `card_ace` = 0. LFSR = 16'hACE1; buffer contents don't-care.
- Asserting `rst` mid-fill or mid-draw forces IDLE immediately. A partially filled deck is discarded.
- Start latency: `start` at edge N makes `busy` = 1 after edge N; the first sample is taken in that cycle.
- Fill latency: DECK_SIZE + (number of rejected samples) cycles. Each cycle is either one accepted card or one rejection.
- Draw latency: 1 cycle from a `draw_req` edge to `card_valid`.
  - Back-to-back draws are supported: `draw_req` held high delivers one card per cycle until EMPTY, and exactly `cards_left` pulses are produced.
  - The last draw's pulse and `deck_empty` = 1 appear in the same cycle.
- `cards_left` updates on the same edge as the corresponding write or `card_valid`.

## Test plan
- Reset, then `start` with `seed` = 0 (LFSR = ACE1):
  - First five samples give cards 2, A(1, ace=1), 9, 10, then a rejection. The intermediate states are E270, 7138, 389C, 1C4E.
  - `cards_left` reads 4 after cycle 5.
- Full fill with `seed` = 16'h0001, DECK_SIZE = 12:
  - `busy` lasts exactly 12 + rejects cycles; `deck_ready` rises the cycle after the 12th write; `cards_left` = 12.
  - Card sequence matches the reference LFSR model.
- Hold `draw_req` high for 14 cycles in READY:
  - 12 `card_valid` pulses in model order; `cards_left` counts 12 -> 0.
  - `deck_empty` = 1 on the 12th pulse; no further pulses.
- `draw_req` during FILL and `start` during FILL: no pulse, and the fill sequence is unchanged.
- `start` and `draw_req` together in READY: no `card_valid`; `busy` next cycle; `cards_left` cleared to 0.
- `rst` low mid-fill after 5 cards: all outputs 0 immediately. A subsequent `start` with the same seed reproduces an identical card sequence.

Source files
------------

// File: rtl/card_deck_gen.sv
// card_deck_gen: pseudo-random blackjack deck source.
// A 16-bit Galois LFSR fills a DECK_SIZE-entry buffer through rejection
// sampling. Cards are then served one per draw_req with a registered pulse.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FILL  | one LFSR sample per cycle, accepted samples written to the buffer
// READY | deck filled, cards served on draw_req
// EMPTY | every card drawn, waiting for a new start
//
// DECK_SIZE must be in 2..15 and 2**CNT_W must exceed DECK_SIZE.
module card_deck_gen #(
    parameter int DECK_SIZE = 12,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic             draw_req,
    output logic             busy,
    output logic             deck_ready,
    output logic             deck_empty,
    output logic             card_valid,
    output logic [3:0]       card_val,
    output logic             card_ace,
    output logic [CNT_W-1:0] cards_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        EMPTY = 2'd3
    } state_t;

    localparam logic [15:0]      SEED_DFLT = 16'hACE1;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DECK_SIZE - 1);

    state_t             state;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   rd_ptr;
    logic [4:0]         deck_mem [DECK_SIZE];

    logic [3:0]         sample_r;
    logic [3:0]         sample_rank;
    logic               sample_ok;
    logic [4:0]         sample_card;
    logic               start_ok;
    logic               wr_en;
    logic               draw_ok;

    // Sample decode, LFSR next state and request qualification.
    always_comb begin
        sample_r    = lfsr[3:0];
        sample_ok   = (sample_r <= 4'd12);
        sample_rank = sample_r + 4'd1;
        sample_card = {(sample_rank == 4'd1),
                       (sample_rank > 4'd10) ? 4'd10 : sample_rank};
        lfsr_next   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        start_ok    = start && (state != FILL);
        wr_en       = (state == FILL) && sample_ok;
        draw_ok     = (state == READY) && draw_req && !start;
    end

    // Card buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            deck_mem[wr_ptr] <= sample_card;
        end
    end

    // Sequencer: start handling, fill sampling and card delivery.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lfsr       <= SEED_DFLT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cards_left <= '0;
            card_valid <= 1'b0;
            card_val   <= 4'd0;
            card_ace   <= 1'b0;
        end else begin
            card_valid <= 1'b0;
            if (start_ok) begin
                // start wins over a simultaneous draw_req in READY
                lfsr       <= (seed == 16'h0000) ? SEED_DFLT : seed;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                cards_left <= '0;
                state      <= FILL;
            end else begin
                case (state)
                    FILL: begin
                        // the LFSR steps every fill cycle, rejected or not
                        lfsr <= lfsr_next;
                        if (wr_en) begin
                            wr_ptr     <= wr_ptr + CNT_ONE;
                            cards_left <= cards_left + CNT_ONE;
                            if (cards_left == FILL_LAST) begin
                                state <= READY;
                            end
                        end
                    end
                    READY: begin
                        if (draw_ok) begin
                            card_valid <= 1'b1;
                            card_val   <= deck_mem[rd_ptr][3:0];
                            card_ace   <= deck_mem[rd_ptr][4];
                            rd_ptr     <= rd_ptr + CNT_ONE;
                            cards_left <= cards_left - CNT_ONE;
                            if (cards_left == CNT_ONE) begin
                                state <= EMPTY;
                            end
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    // Status flags decode straight from the state register.
    always_comb begin
        busy       = (state == FILL);
        deck_ready = (state == READY);
        deck_empty = (state == EMPTY);
    end

endmodule

// File: tb/tb_card_deck_gen.sv
// Self-checking bench for card_deck_gen: a reference LFSR model fills a
// scoreboard queue when a start is driven; drawn cards pop and compare.
module tb_card_deck_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        draw_req = 1'b0;
    logic        busy;
    logic        deck_ready;
    logic        deck_empty;
    logic        card_valid;
    logic [3:0]  card_val;
    logic        card_ace;
    logic [3:0]  cards_left;

    int          checks = 0;
    int          failures = 0;
    logic [4:0]  exp_q[$];
    int          exp_fill_cycles;

    card_deck_gen #(.DECK_SIZE(12), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .draw_req   (draw_req),
        .busy       (busy),
        .deck_ready (deck_ready),
        .deck_empty (deck_empty),
        .card_valid (card_valid),
        .card_val   (card_val),
        .card_ace   (card_ace),
        .cards_left (cards_left)
    );

    always #5 clk = ~clk;

    // Reference deck: walk the LFSR until 12 cards are accepted.
    task automatic model_fill(input logic [15:0] sd);
        logic [15:0] s;
        int          n;
        int          r;
        int          rank;
        int          v;
        s = (sd == 16'h0000) ? 16'hACE1 : sd;
        n = 0;
        exp_fill_cycles = 0;
        while (n < 12) begin
            r = int'(s[3:0]);
            exp_fill_cycles++;
            if (r < 13) begin
                rank = r + 1;
                v = (rank > 10) ? 10 : rank;
                exp_q.push_back({(rank == 1), v[3:0]});
                n++;
            end
            if (s[0]) s = (s >> 1) ^ 16'hB400;
            else      s = s >> 1;
        end
    endtask

    task automatic wait_ready(output int busy_cyc, output bit ok);
        busy_cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (deck_ready) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
        end
    endtask

    task automatic pulse_start(input logic [15:0] sd);
        seed = sd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({busy, deck_ready, deck_empty, card_valid, card_val, card_ace, cards_left} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0",
                     {busy, deck_ready, deck_empty, card_valid, card_val, card_ace, cards_left});
        end
        @(negedge clk);
        rst = 1'b1;
        draw_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        draw_req = 1'b0;
        checks++;
        if ({busy, deck_ready, card_valid, cards_left} !== 7'd0) begin
            failures++;
            $display("FAIL idle_draw_ignored: got %b required 0",
                     {busy, deck_ready, card_valid, cards_left});
        end
    endtask

    task automatic test_seed0;
        int         exp_cl[5] = '{1, 2, 3, 4, 4};
        logic [4:0] exp_c[4]  = '{5'h02, 5'h11, 5'h09, 5'h0A};
        int         bc;
        bit         ok;
        pulse_start(16'h0000);
        checks++;
        if (busy !== 1'b1 || cards_left !== 4'd0) begin
            failures++;
            $display("FAIL seed0_start: busy=%b cards_left=%0d required busy=1 cards_left=0", busy, cards_left);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (cards_left !== exp_cl[i][3:0]) begin
                failures++;
                $display("FAIL seed0_count[%0d]: got %0d required %0d", i, cards_left, exp_cl[i]);
            end
        end
        wait_ready(bc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL seed0_ready: deck_ready got 0 required 1 within budget");
        end
        for (int i = 0; i < 4; i++) begin
            draw_req = 1'b1;
            @(posedge clk); #1;
            draw_req = 1'b0;
            checks++;
            if (card_valid !== 1'b1 || {card_ace, card_val} !== exp_c[i] || cards_left !== 4'(11 - i)) begin
                failures++;
                $display("FAIL seed0_card[%0d]: valid=%b card=%h left=%0d required valid=1 card=%h left=%0d",
                         i, card_valid, {card_ace, card_val}, cards_left, exp_c[i], 11 - i);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (card_valid !== 1'b0 || {card_ace, card_val} !== 5'h0A) begin
            failures++;
            $display("FAIL seed0_hold: valid=%b card=%h required valid=0 card=0a", card_valid, {card_ace, card_val});
        end
    endtask

    task automatic test_full_fill;
        int bc;
        bit ok;
        exp_q.delete();
        model_fill(16'h0001);
        pulse_start(16'h0001);
        bc = busy ? 1 : 0;
        begin
            int more;
            wait_ready(more, ok);
            bc += more;
        end
        checks++;
        if (!ok || bc != exp_fill_cycles) begin
            failures++;
            $display("FAIL full_fill_latency: ready=%b busy_cycles=%0d required ready=1 busy_cycles=%0d",
                     ok, bc, exp_fill_cycles);
        end
        checks++;
        if (cards_left !== 4'd12 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_fill_count: cards_left=%0d busy=%b required 12 and 0", cards_left, busy);
        end
    endtask

    task automatic test_back_to_back(input string name);
        int         pulses;
        logic [4:0] exp_card;
        logic [4:0] last;
        pulses = 0;
        last = 5'h00;
        draw_req = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (card_valid) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra_pulse: got card %h required no pulse", name, {card_ace, card_val});
                end else begin
                    exp_card = exp_q.pop_front();
                    last = exp_card;
                    if ({card_ace, card_val} !== exp_card || cards_left !== 4'(12 - pulses)
                        || deck_empty !== (pulses == 12)) begin
                        failures++;
                        $display("FAIL %s_card[%0d]: card=%h left=%0d empty=%b required card=%h left=%0d empty=%b",
                                 name, pulses, {card_ace, card_val}, cards_left, deck_empty,
                                 exp_card, 12 - pulses, (pulses == 12));
                    end
                end
            end
        end
        draw_req = 1'b0;
        checks++;
        if (pulses != 12 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pulse_count: got %0d required 12 (unconsumed %0d)", name, pulses, exp_q.size());
        end
        @(posedge clk); #1;
        checks++;
        if (deck_empty !== 1'b1 || cards_left !== 4'd0 || card_valid !== 1'b0 || {card_ace, card_val} !== last) begin
            failures++;
            $display("FAIL %s_empty_hold: empty=%b left=%0d valid=%b card=%h required 1 0 0 %h",
                     name, deck_empty, cards_left, card_valid, {card_ace, card_val}, last);
        end
    endtask

    task automatic test_fill_interference;
        int bc;
        int more;
        bit ok;
        exp_q.delete();
        model_fill(16'h1234);
        pulse_start(16'h1234);
        bc = busy ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            draw_req = 1'b1;
            seed = 16'hFFFF;
            start = (i == 2 || i == 5);
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) bc++;
            checks++;
            if (card_valid !== 1'b0) begin
                failures++;
                $display("FAIL fill_draw_pulse[%0d]: card_valid got 1 required 0", i);
            end
        end
        draw_req = 1'b0;
        wait_ready(more, ok);
        bc += more;
        checks++;
        if (!ok || bc != exp_fill_cycles) begin
            failures++;
            $display("FAIL fill_interference_latency: ready=%b busy_cycles=%0d required 1 and %0d",
                     ok, bc, exp_fill_cycles);
        end
        test_back_to_back("fill_interference");
    endtask

    task automatic test_start_draw_ready;
        int bc;
        bit ok;
        exp_q.delete();
        model_fill(16'hBEEF);
        pulse_start(16'hBEEF);
        wait_ready(bc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL start_draw_ready_fill: deck_ready got 0 required 1");
        end
        seed = 16'h5A5A;
        start = 1'b1;
        draw_req = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        draw_req = 1'b0;
        checks++;
        if (card_valid !== 1'b0 || busy !== 1'b1 || cards_left !== 4'd0) begin
            failures++;
            $display("FAIL start_wins: valid=%b busy=%b left=%0d required 0 1 0", card_valid, busy, cards_left);
        end
        exp_q.delete();
        model_fill(16'h5A5A);
        wait_ready(bc, ok);
        checks++;
        if (!ok || bc + 1 != exp_fill_cycles) begin
            failures++;
            $display("FAIL start_wins_refill: ready=%b busy_cycles=%0d required 1 and %0d", ok, bc + 1, exp_fill_cycles);
        end
        test_back_to_back("start_wins");
    endtask

    task automatic test_reset_midfill;
        int bc;
        bit ok;
        bit hit;
        exp_q.delete();
        model_fill(16'hC0DE);
        pulse_start(16'hC0DE);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cards_left == 4'd5) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!hit || busy !== 1'b1) begin
            failures++;
            $display("FAIL midfill_reach5: reached=%b busy=%b required 1 1", hit, busy);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, deck_ready, deck_empty, card_valid, card_val, card_ace, cards_left} !== 14'd0) begin
            failures++;
            $display("FAIL midfill_reset: got %b required 0",
                     {busy, deck_ready, deck_empty, card_valid, card_val, card_ace, cards_left});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        pulse_start(16'hC0DE);
        bc = busy ? 1 : 0;
        begin
            int more;
            wait_ready(more, ok);
            bc += more;
        end
        checks++;
        if (!ok || bc != exp_fill_cycles) begin
            failures++;
            $display("FAIL midfill_refill: ready=%b busy_cycles=%0d required 1 and %0d", ok, bc, exp_fill_cycles);
        end
        test_back_to_back("after_reset");
    endtask

    initial begin
        test_reset();
        test_seed0();
        test_full_fill();
        test_back_to_back("full_deck");
        test_fill_interference();
        test_start_draw_ready();
        test_reset_midfill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
